// File: rtl/pipe_ctrl_cc.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_cc
//   Pipeline control unit for the 5-stage Y86-64 core. Holds the committed
//   condition codes {ZF,SF,OF}, evaluates the jump/cmov condition for the
//   instruction in Execute, and drives the stall/bubble controls of the
//   F/D/E/M/W pipeline registers. Also tracks the processor run state
//   (RUN/HALTED), the registered architectural status, and the cycle and
//   bubble performance counters.
//
// Parameters
//   CC_RESET  reset value of {ZF,SF,OF}
//   CNT_W     width of the performance counters
//
// Ports
//   clk                       clock, rising edge
//   reset                     asynchronous active-high reset
//   D_icode                   icode in Decode register
//   d_srcA, d_srcB            Decode source registers (4'hF = none)
//   E_icode, E_ifun           icode/ifun in Execute register
//   E_destM                   Execute memory destination (4'hF = none)
//   alu_zf, alu_sf, alu_of    raw ALU flags for the current E instruction
//   M_icode                   icode in Memory register
//   m_stat                    status leaving the memory stage
//   W_stat                    status in Writeback register
//   e_cnd                     condition result of E_ifun against committed CC
//   cc                        committed {ZF,SF,OF}
//   F_stall .. W_stall        pipeline register controls
//   halted                    processor has stopped
//   proc_stat                 registered architectural status
//   cyc_cnt                   cycles spent in RUN
//   bub_cnt                   RUN cycles with E_bubble asserted
// ---------------------------------------------------------------------------
module pipe_ctrl_cc #(
    parameter logic [2:0]  CC_RESET = 3'b100,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [3:0]       E_destM,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             e_cnd,
    output logic [2:0]       cc,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [3:0]       proc_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] bub_cnt
);

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cc_q, cc_d;
    logic [3:0]       stat_q, stat_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] bub_q, bub_d;

    logic load_use;
    logic ret_pend;
    logic mispred;
    logic m_exc;
    logic w_exc;
    logic set_cc;

    function automatic logic is_exc(input logic [3:0] s);
        return (s == 4'h2) || (s == 4'h3) || (s == 4'h4);
    endfunction

    // Condition evaluation always uses the committed CC; the instruction
    // that sets CC is the one in E, so no forwarding path is required.
    always_comb begin
        logic z, s, o;
        z = cc_q[2];
        s = cc_q[1];
        o = cc_q[0];
        e_cnd = 1'b0;
        case (E_ifun)
            4'h0:    e_cnd = 1'b1;
            4'h1:    e_cnd = (s ^ o) | z;
            4'h2:    e_cnd = s ^ o;
            4'h3:    e_cnd = z;
            4'h4:    e_cnd = ~z;
            4'h5:    e_cnd = ~(s ^ o);
            4'h6:    e_cnd = ~(s ^ o) & ~z;
            default: e_cnd = 1'b0;
        endcase
    end

    always_comb begin
        load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                   (E_destM != R_NONE) &&
                   ((E_destM == d_srcA) || (E_destM == d_srcB));
        ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred  = (E_icode == I_JXX) && !e_cnd;
        m_exc    = is_exc(m_stat);
        w_exc    = is_exc(W_stat);
    end

    always_comb begin
        state_d  = state_q;
        stat_d   = stat_q;
        cc_d     = cc_q;
        cyc_d    = cyc_q;
        bub_d    = bub_q;
        set_cc   = 1'b0;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;

        case (state_q)
            ST_RUN: begin
                F_stall  = load_use | ret_pend;
                D_stall  = load_use;
                // load-use stalls D, so a pending ret must not also bubble it
                D_bubble = mispred | (ret_pend & ~load_use);
                E_bubble = mispred | load_use;
                M_bubble = m_exc | w_exc;
                W_stall  = w_exc;

                set_cc = (E_icode == I_OPQ) && !m_exc && !w_exc;
                if (set_cc) begin
                    cc_d = {alu_zf, alu_sf, alu_of};
                end

                cyc_d = cyc_q + CNT_ONE;
                if (E_bubble) begin
                    bub_d = bub_q + CNT_ONE;
                end

                if (W_stat != S_AOK) begin
                    state_d = ST_HALTED;
                    stat_d  = W_stat;
                end
            end
            ST_HALTED: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cc_q    <= CC_RESET;
            stat_q  <= S_AOK;
            cyc_q   <= '0;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            stat_q  <= stat_d;
            cyc_q   <= cyc_d;
            bub_q   <= bub_d;
        end
    end

    assign cc        = cc_q;
    assign halted    = (state_q == ST_HALTED);
    assign proc_stat = stat_q;
    assign cyc_cnt   = cyc_q;
    assign bub_cnt   = bub_q;

endmodule
